// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage.
// ALU opcodes, forward-select codes and multiplier FSM states.
package ex_pkg;

   localparam logic [3:0] ALU_SLL  = 4'd0;
   localparam logic [3:0] ALU_SRA  = 4'd1;
   localparam logic [3:0] ALU_SRL  = 4'd2;
   localparam logic [3:0] ALU_MUL  = 4'd3;
   localparam logic [3:0] ALU_ADD  = 4'd5;
   localparam logic [3:0] ALU_SUB  = 4'd6;
   localparam logic [3:0] ALU_AND  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_XOR  = 4'd9;
   localparam logic [3:0] ALU_NOR  = 4'd10;
   localparam logic [3:0] ALU_SLT  = 4'd11;
   localparam logic [3:0] ALU_SLTU = 4'd12;

   localparam logic [1:0] FWD_RF    = 2'd0;
   localparam logic [1:0] FWD_EXMEM = 2'd1;
   localparam logic [1:0] FWD_WB    = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } mul_state_e;

endpackage

// File: rtl/ex_serial_mul.sv
// Serial shift-add multiplier, one multiplier bit per clock.
// A start pulse latches operands and clears the accumulator.
module ex_serial_mul (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        last,
   output logic        done,
   output logic [31:0] product
);

   logic [31:0] mcand;
   logic [31:0] mplier;
   logic [31:0] acc;
   logic [4:0]  cnt;
   logic        run;

   assign last    = run && (cnt == 5'd31);
   assign product = acc;

   // Latch on start, then add/shift once per cycle for 32 cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         run    <= 1'b0;
         done   <= 1'b0;
      end else if (start) begin
         mcand  <= a;
         mplier <= b;
         acc    <= '0;
         cnt    <= '0;
         run    <= 1'b1;
         done   <= 1'b0;
      end else if (run) begin
         if (mplier[0])
            acc <= acc + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 5'd1;
         if (last) begin
            run  <= 1'b0;
            done <= 1'b1;
         end
      end else begin
         done <= 1'b0;
      end
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarding, ALU, branch resolve, EX/MEM register.
// EX_MULT_EN selects the serial multiplier with front-end stall.
module ex_stage
   import ex_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        Effective_in,
   input  logic [31:0] PC_in,
   input  logic [31:0] IR_in,
   input  logic        Syscall_in,
   input  logic        JAL_in,
   input  logic        RegWrite_in,
   input  logic        MemToReg_in,
   input  logic        MemWrite_in,
   input  logic        JR_in,
   input  logic        JMP_in,
   input  logic        Beq_in,
   input  logic        Bne_in,
   input  logic [3:0]  AluOP_in,
   input  logic        AluSrcB_in,
   input  logic [31:0] R1_in,
   input  logic [31:0] R2_in,
   input  logic [1:0]  R1_forward_in,
   input  logic [1:0]  R2_forward_in,
   input  logic [31:0] EXMEM_fwd,
   input  logic [31:0] WB_fwd,
   input  logic [4:0]  Rd_no_in,
   input  logic [31:0] Imm_in,
   input  logic [4:0]  Shamt_in,
   input  logic [25:0] J_Addr_in,
   output logic        Stall,
   output logic        Redirect,
   output logic [31:0] Redirect_PC,
   output logic        Effective_out,
   output logic [31:0] PC_out,
   output logic [31:0] IR_out,
   output logic        Syscall_out,
   output logic        RegWrite_out,
   output logic        MemToReg_out,
   output logic        MemWrite_out,
   output logic [31:0] AluResult_out,
   output logic [31:0] StoreData_out,
   output logic [4:0]  Rd_no_out
);

   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [31:0] alu_b;
   logic [31:0] alu_y;
   logic [31:0] pc4;
   logic [31:0] mul_y;
   logic        take;

   assign pc4   = PC_in + 32'd4;
   assign alu_b = AluSrcB_in ? Imm_in : op_b;
   assign take  = Effective_in && !Stall;

   // Forwarding muxes for both operands.
   always_comb begin
      case (R1_forward_in)
         FWD_EXMEM: op_a = EXMEM_fwd;
         FWD_WB:    op_a = WB_fwd;
         default:   op_a = R1_in;
      endcase
      case (R2_forward_in)
         FWD_EXMEM: op_b = EXMEM_fwd;
         FWD_WB:    op_b = WB_fwd;
         default:   op_b = R2_in;
      endcase
   end

`ifdef EX_MULT_EN
   mul_state_e  state;
   logic        mul_start;
   logic        mul_last;
   logic        mul_done;
   logic [31:0] mul_p;

   assign mul_start = (state == ST_IDLE) && Effective_in
                      && (AluOP_in == ALU_MUL);
   assign Stall     = mul_start || (state == ST_BUSY);
   assign mul_y     = mul_done ? mul_p : 32'd0;

   // Multiplier sequencing: detect, 32 busy cycles, one done cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         unique case (state)
            ST_IDLE: if (mul_start) state <= ST_BUSY;
            ST_BUSY: if (mul_last)  state <= ST_DONE;
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   ex_serial_mul u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (op_a),
      .b       (op_b),
      .last    (mul_last),
      .done    (mul_done),
      .product (mul_p)
   );
`else
   assign Stall = 1'b0;
   assign mul_y = op_a * op_b;
`endif

   // ALU; shifts and multiply use the forwarded operand B.
   always_comb begin
      case (AluOP_in)
         ALU_SLL:  alu_y = op_b << Shamt_in;
         ALU_SRA:  alu_y = $signed(op_b) >>> Shamt_in;
         ALU_SRL:  alu_y = op_b >> Shamt_in;
         ALU_MUL:  alu_y = mul_y;
         ALU_ADD:  alu_y = op_a + alu_b;
         ALU_SUB:  alu_y = op_a - alu_b;
         ALU_AND:  alu_y = op_a & alu_b;
         ALU_OR:   alu_y = op_a | alu_b;
         ALU_XOR:  alu_y = op_a ^ alu_b;
         ALU_NOR:  alu_y = ~(op_a | alu_b);
         ALU_SLT:  alu_y = {31'd0, $signed(op_a) < $signed(alu_b)};
         ALU_SLTU: alu_y = {31'd0, op_a < alu_b};
         default:  alu_y = 32'd0;
      endcase
   end

   // Branch/jump resolution; JR beats jumps beats branches.
   always_comb begin
      Redirect    = 1'b0;
      Redirect_PC = pc4 + (Imm_in << 2);
      if (take) begin
         if (JR_in) begin
            Redirect    = 1'b1;
            Redirect_PC = op_a;
         end else if (JMP_in || JAL_in) begin
            Redirect    = 1'b1;
            Redirect_PC = {pc4[31:28], J_Addr_in, 2'b00};
         end else if ((Beq_in && op_a == op_b)
                   || (Bne_in && op_a != op_b)) begin
            Redirect    = 1'b1;
         end
      end
   end

   // EX/MEM register; a stalled or empty slot becomes a bubble.
   always_ff @(posedge clk) begin
      if (rst || !take) begin
         Effective_out <= 1'b0;
         PC_out        <= '0;
         IR_out        <= '0;
         Syscall_out   <= 1'b0;
         RegWrite_out  <= 1'b0;
         MemToReg_out  <= 1'b0;
         MemWrite_out  <= 1'b0;
         AluResult_out <= '0;
         StoreData_out <= '0;
         Rd_no_out     <= '0;
      end else begin
         Effective_out <= 1'b1;
         PC_out        <= PC_in;
         IR_out        <= IR_in;
         Syscall_out   <= Syscall_in;
         RegWrite_out  <= RegWrite_in;
         MemToReg_out  <= MemToReg_in;
         MemWrite_out  <= MemWrite_in;
         AluResult_out <= JAL_in ? pc4 : alu_y;
         StoreData_out <= op_b;
         Rd_no_out     <= JAL_in ? 5'd31 : Rd_no_in;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Randomized bench for ex_stage against a cycle-level reference model.
// Honours EX_MULT_EN to expect serial or single-cycle multiply.
module tb_ex_stage;

`ifdef EX_MULT_EN
   localparam bit MULT = 1'b1;
`else
   localparam bit MULT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic Effective_in;
   logic [31:0] PC_in, IR_in;
   logic Syscall_in, JAL_in, RegWrite_in, MemToReg_in, MemWrite_in;
   logic JR_in, JMP_in, Beq_in, Bne_in;
   logic [3:0] AluOP_in;
   logic AluSrcB_in;
   logic [31:0] R1_in, R2_in;
   logic [1:0] R1_forward_in, R2_forward_in;
   logic [31:0] EXMEM_fwd, WB_fwd;
   logic [4:0] Rd_no_in;
   logic [31:0] Imm_in;
   logic [4:0] Shamt_in;
   logic [25:0] J_Addr_in;
   logic Stall, Redirect;
   logic [31:0] Redirect_PC;
   logic Effective_out;
   logic [31:0] PC_out, IR_out;
   logic Syscall_out, RegWrite_out, MemToReg_out, MemWrite_out;
   logic [31:0] AluResult_out, StoreData_out;
   logic [4:0] Rd_no_out;

   always #5 clk = ~clk;

   ex_stage dut (
      .clk(clk), .rst(rst), .Effective_in(Effective_in),
      .PC_in(PC_in), .IR_in(IR_in), .Syscall_in(Syscall_in),
      .JAL_in(JAL_in), .RegWrite_in(RegWrite_in),
      .MemToReg_in(MemToReg_in), .MemWrite_in(MemWrite_in),
      .JR_in(JR_in), .JMP_in(JMP_in), .Beq_in(Beq_in), .Bne_in(Bne_in),
      .AluOP_in(AluOP_in), .AluSrcB_in(AluSrcB_in),
      .R1_in(R1_in), .R2_in(R2_in),
      .R1_forward_in(R1_forward_in), .R2_forward_in(R2_forward_in),
      .EXMEM_fwd(EXMEM_fwd), .WB_fwd(WB_fwd), .Rd_no_in(Rd_no_in),
      .Imm_in(Imm_in), .Shamt_in(Shamt_in), .J_Addr_in(J_Addr_in),
      .Stall(Stall), .Redirect(Redirect), .Redirect_PC(Redirect_PC),
      .Effective_out(Effective_out), .PC_out(PC_out), .IR_out(IR_out),
      .Syscall_out(Syscall_out), .RegWrite_out(RegWrite_out),
      .MemToReg_out(MemToReg_out), .MemWrite_out(MemWrite_out),
      .AluResult_out(AluResult_out), .StoreData_out(StoreData_out),
      .Rd_no_out(Rd_no_out)
   );

   int pass = 0;
   int total = 0;
   bit chk_en = 1'b0;
   logic st_s = 1'b0;

   task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got === exp) pass++;
      else $display("FAIL %s got %h exp %h", n, got, exp);
   endtask

   function automatic logic [31:0] fwd(logic [1:0] s, logic [31:0] rf);
      if (s == 2'd1) return EXMEM_fwd;
      if (s == 2'd2) return WB_fwd;
      return rf;
   endfunction

   function automatic logic [31:0] alu_ref(logic [3:0] op,
         logic [31:0] a, logic [31:0] b, logic [31:0] b2,
         logic [4:0] sh, logic [31:0] prod);
      case (op)
         4'd0:  return b << sh;
         4'd1:  return $signed(b) >>> sh;
         4'd2:  return b >> sh;
         4'd3:  return prod;
         4'd5:  return a + b2;
         4'd6:  return a - b2;
         4'd7:  return a & b2;
         4'd8:  return a | b2;
         4'd9:  return a ^ b2;
         4'd10: return ~(a | b2);
         4'd11: return ($signed(a) < $signed(b2)) ? 32'd1 : 32'd0;
         4'd12: return (a < b2) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   // model state: expected EX/MEM contents and MUL residency
   logic q_eff = 0, q_rw = 0, q_mw = 0, q_mtr = 0, q_sys = 0;
   logic q_full = 0;
   logic [31:0] q_pc = 0, q_ir = 0, q_res = 0, q_sd = 0;
   logic [4:0] q_rd = 0;
   int age = 0;
   logic [31:0] ma = 0, mb = 0;

   // compare process: check registered and combinational outputs
   always @(negedge clk) begin
      logic [31:0] a, b, b2, prod, tgt, pc4;
      logic xs, xr;
      st_s = Stall;
      if (chk_en) begin
         chk("eff_out", {31'd0, Effective_out}, {31'd0, q_eff});
         chk("regwrite_out", {31'd0, RegWrite_out}, {31'd0, q_rw});
         chk("memwrite_out", {31'd0, MemWrite_out}, {31'd0, q_mw});
         if (q_full) begin
            chk("memtoreg_out", {31'd0, MemToReg_out}, {31'd0, q_mtr});
            chk("syscall_out", {31'd0, Syscall_out}, {31'd0, q_sys});
            chk("pc_out", PC_out, q_pc);
            chk("ir_out", IR_out, q_ir);
            chk("result", AluResult_out, q_res);
            chk("storedata", StoreData_out, q_sd);
            chk("rd_out", {27'd0, Rd_no_out}, {27'd0, q_rd});
         end
      end
      a   = fwd(R1_forward_in, R1_in);
      b   = fwd(R2_forward_in, R2_in);
      b2  = AluSrcB_in ? Imm_in : b;
      pc4 = PC_in + 32'd4;
      xs  = MULT && Effective_in && AluOP_in == 4'd3 && age < 33;
      xr  = 1'b0;
      tgt = 32'd0;
      if (Effective_in && !xs) begin
         if (JR_in) begin xr = 1; tgt = a; end
         else if (JMP_in || JAL_in) begin
            xr = 1; tgt = {pc4[31:28], J_Addr_in, 2'b00};
         end else if ((Beq_in && a == b) || (Bne_in && a != b)) begin
            xr = 1; tgt = pc4 + (Imm_in << 2);
         end
      end
      if (chk_en) begin
         chk("stall", {31'd0, Stall}, {31'd0, xs});
         chk("redirect", {31'd0, Redirect}, {31'd0, xr});
         if (xr) chk("redirect_pc", Redirect_PC, tgt);
      end
      if (MULT && Effective_in && AluOP_in == 4'd3 && age == 0) begin
         ma = a; mb = b;
      end
      prod = MULT ? ma * mb : a * b;
      q_full = rst || (Effective_in && !xs);
      if (rst || !(Effective_in && !xs)) begin
         q_eff = 0; q_rw = 0; q_mw = 0; q_mtr = 0; q_sys = 0;
         q_pc = 0; q_ir = 0; q_res = 0; q_sd = 0; q_rd = 0;
      end else begin
         q_eff = 1; q_rw = RegWrite_in; q_mw = MemWrite_in;
         q_mtr = MemToReg_in; q_sys = Syscall_in;
         q_pc = PC_in; q_ir = IR_in; q_sd = b;
         q_res = JAL_in ? pc4
               : alu_ref(AluOP_in, a, b, b2, Shamt_in, prod);
         q_rd = JAL_in ? 5'd31 : Rd_no_in;
      end
      if (rst) age = 0;
      else if (MULT && Effective_in && AluOP_in == 4'd3)
         age = xs ? age + 1 : 0;
      else age = 0;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bubble();
      Effective_in = 0; PC_in = 0; IR_in = 0; Syscall_in = 0;
      JAL_in = 0; RegWrite_in = 0; MemToReg_in = 0; MemWrite_in = 0;
      JR_in = 0; JMP_in = 0; Beq_in = 0; Bne_in = 0;
      AluOP_in = 0; AluSrcB_in = 0; R1_in = 0; R2_in = 0;
      R1_forward_in = 0; R2_forward_in = 0; EXMEM_fwd = 0; WB_fwd = 0;
      Rd_no_in = 0; Imm_in = 0; Shamt_in = 0; J_Addr_in = 0;
   endtask

   task automatic alu_op(logic [3:0] op, logic [31:0] r1, logic [31:0] r2);
      bubble();
      Effective_in = 1; RegWrite_in = 1; AluOP_in = op;
      R1_in = r1; R2_in = r2; Rd_no_in = 5'd7;
      PC_in = 32'h0000_0200; IR_in = 32'h1234_5678;
   endtask

   task automatic rand_instr();
      bubble();
      Effective_in  = ($urandom_range(0, 7) != 0);
      PC_in         = {$urandom, 2'b00} >> 2 << 2;
      IR_in         = $urandom;
      Syscall_in    = ($urandom_range(0, 7) == 0);
      RegWrite_in   = $urandom_range(0, 1);
      MemToReg_in   = $urandom_range(0, 1);
      MemWrite_in   = $urandom_range(0, 1);
      JAL_in        = ($urandom_range(0, 9) == 0);
      JR_in         = ($urandom_range(0, 9) == 0);
      JMP_in        = ($urandom_range(0, 9) == 0);
      Beq_in        = ($urandom_range(0, 5) == 0);
      Bne_in        = ($urandom_range(0, 5) == 0);
      AluOP_in      = 4'($urandom_range(0, 15));
      AluSrcB_in    = (AluOP_in <= 4'd3) ? 1'b0 : 1'($urandom_range(0, 1));
      R1_in         = $urandom;
      R2_in         = $urandom;
      R1_forward_in = 2'($urandom_range(0, 3));
      R2_forward_in = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
         R2_in = R1_in; R2_forward_in = R1_forward_in;
      end
      EXMEM_fwd     = $urandom;
      WB_fwd        = $urandom;
      Rd_no_in      = 5'($urandom_range(0, 31));
      Imm_in        = $urandom;
      Shamt_in      = 5'($urandom_range(0, 31));
      J_Addr_in     = 26'($urandom);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int holds;
      bubble();
      rst = 1;
      step();
      step();
      rst = 0;
      chk("reset_eff", {31'd0, Effective_out}, 32'd0);
      chk("reset_rd", {27'd0, Rd_no_out}, 32'd0);
      chk("reset_res", AluResult_out, 32'd0);
      chk("reset_stall", {31'd0, Stall}, 32'd0);
      chk_en = 1;

      alu_op(4'd5, 32'h7FFF_FFFF, 32'd1);
      step();
      chk("add_ovf", AluResult_out, 32'h8000_0000);
      chk("add_eff", {31'd0, Effective_out}, 32'd1);

      alu_op(4'd6, 32'd99, 32'd3);
      R1_forward_in = 2'd1; EXMEM_fwd = 32'd10;
      step();
      chk("sub_fwd", AluResult_out, 32'd7);

      bubble();
      Effective_in = 1; Beq_in = 1; R1_in = 5; R2_in = 5;
      PC_in = 32'h100; Imm_in = 32'hFFFF_FFFE;
      #1;
      chk("beq_redirect", {31'd0, Redirect}, 32'd1);
      chk("beq_target", Redirect_PC, 32'h0000_00FC);
      Beq_in = 0; Bne_in = 1;
      #1;
      chk("bne_redirect", {31'd0, Redirect}, 32'd0);

      step();
      bubble();
      Effective_in = 1; JAL_in = 1; RegWrite_in = 1;
      PC_in = 32'h0040_0010; J_Addr_in = 26'h010_0004; Rd_no_in = 5'd3;
      #1;
      chk("jal_target", Redirect_PC, 32'h0040_0010);
      step();
      chk("jal_link", AluResult_out, 32'h0040_0014);
      chk("jal_rd", {27'd0, Rd_no_out}, 32'd31);

      alu_op(4'd3, 32'hFFFF_FFFF, 32'd3);
      n = 0;
      while (Stall && n < 40) begin
         n++;
         EXMEM_fwd = $urandom; WB_fwd = $urandom;
         step();
      end
      chk("mul_stall_cycles", n, MULT ? 32'd33 : 32'd0);
      step();
      chk("mul_result", AluResult_out, 32'hFFFF_FFFD);

      alu_op(4'd3, 32'd12345, 32'd678);
      repeat (11) step();
      rst = 1;
      step();
      rst = 0;
      alu_op(4'd5, 32'd2, 32'd2);
      chk("rstmid_eff", {31'd0, Effective_out}, 32'd0);
      chk("rstmid_res", AluResult_out, 32'd0);
      chk("rstmid_rd", {27'd0, Rd_no_out}, 32'd0);
      chk("rstmid_stall", {31'd0, Stall}, 32'd0);
      step();
      chk("add_after_rst", AluResult_out, 32'd4);

      holds = 0;
      rand_instr();
      for (int i = 0; i < 400; ) begin
         step();
         if (st_s) begin
            holds++;
            EXMEM_fwd = $urandom; WB_fwd = $urandom;
            if (holds > 40) begin
               chk("stall_bound", 32'(holds), 32'd33);
               break;
            end
         end else begin
            holds = 0;
            i++;
            rand_instr();
         end
      end
      bubble();
      step();
      step();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage MIPS pipeline, directly downstream of the ID/EX register, and includes the EX/MEM register. It does three things:
- Selects forwarded operands and runs the ALU.
- Resolves branches, jumps and JR, and issues a PC redirect.
- Executes MUL on a 32-cycle serial shift-add unit, stalling the front end until the product is ready.

## Interface
Parameters: none (widths fixed by the ISA).

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- Effective_in  in  1  instruction in EX is valid (0 = bubble)
- PC_in, IR_in  in  32  instruction address / word
- Syscall_in, JAL_in, RegWrite_in, MemToReg_in, MemWrite_in, JR_in, JMP_in, Beq_in, Bne_in  in  1  decoded controls
- AluOP_in  in  4  ALU operation
- AluSrcB_in  in  1  0 = operand B, 1 = Imm_in
- R1_in, R2_in  in  32  register-file read data
- R1_forward_in, R2_forward_in  in  2  0 = register file, 1 = EXMEM_fwd, 2 = WB_fwd, 3 = register file
- EXMEM_fwd, WB_fwd  in  32  forwarded results from MEM and WB
- Rd_no_in  in  5  destination register
- Imm_in  in  32  sign-extended immediate
- Shamt_in  in  5  shift amount
- J_Addr_in  in  26  jump field
- Stall  out  1  combinational; holds PC, IF/ID and ID/EX
- Redirect  out  1  combinational; flush IF/ID and ID/EX, load Redirect_PC
- Redirect_PC  out  32  combinational target
- Effective_out, PC_out, IR_out, Syscall_out, RegWrite_out, MemToReg_out, MemWrite_out  out  –  registered EX/MEM copies
- AluResult_out  out  32  registered result (PC+4 for JAL)
- StoreData_out  out  32  registered forwarded operand B
- Rd_no_out  out  5  registered destination (31 for JAL)

## Operation
- Operand A = mux(R1_forward_in); operand B = mux(R2_forward_in).
- ALU second input = AluSrcB_in ? Imm_in : operand B.
- AluOP encoding:
  - 0 SLL, 1 SRA, 2 SRL (shift operand B by Shamt_in)
  - 3 MUL (low 32 bits)
  - 5 ADD, 6 SUB, 7 AND, 8 OR, 9 XOR, 10 NOR
  - 11 SLT (signed), 12 SLTU
  - 4, 13–15 give result 0
- All arithmetic is modulo 2^32; no overflow trap.
- Redirect is asserted only when Effective_in=1 and Stall=0. Priority and targets:
  - JR: Redirect_PC = operand A
  - JMP or JAL: Redirect_PC = {PC_in+4 [31:28], J_Addr_in, 2'b00}
  - Beq taken if A==B, Bne taken if A!=B: Redirect_PC = PC_in + 4 + (Imm_in<<2)
- Not-taken branch: Redirect=0. Redirect_PC is a don't-care when Redirect=0.
- JAL: AluResult_out = PC_in+4, Rd_no_out = 31.
- MUL FSM (EX_MULT_EN defined):
  - IDLE: if Effective_in and AluOP_in==3, then Stall=1, latch A and B into the sub-module, clear accumulator, count=0, go to BUSY.
  - BUSY: one multiplier bit per cycle; Stall=1; when count==31, go to DONE.
  - DONE: Stall=0, product is valid, EX/MEM captures it, go to IDLE.
- While Stall=1, EX/MEM loads a bubble: Effective_out and all write-enables are 0.
- Effective_in=0: no redirect, no MUL start; EX/MEM loads a bubble.

## Timing
- Single-cycle ops: result in EX/MEM one edge after entering EX.
- MUL: Stall high for exactly 33 cycles (IDLE detect + 32 BUSY); result in EX/MEM on the edge leaving DONE, i.e. 34 edges after entry.
- Forwarded operands are sampled only in the IDLE detect cycle. Later changes on EXMEM_fwd/WB_fwd caused by the drained bubbles must not affect the product.
- Reset: on a rst edge every registered output goes to 0 (Rd_no_out=0, Effective_out=0) and the FSM goes to IDLE. Stall, and Redirect (which is gated by Stall), read 0 in the first cycle after reset unless a new MUL is present. Reset mid-MUL discards the product.
- A branch directly behind a MUL is resolved only once it is in EX with Stall=0.

## Configuration
- EX_MULT_EN defined: serial multiplier and FSM as above.
- EX_MULT_EN undefined:
  - AluOP 3 computes the low 32 bits of A*B combinationally in one cycle.
  - Stall is tied to 0; no FSM is instantiated.

## Structure
- Package ex_pkg holds:
  - ALU opcode localparams (ALU_SLL … ALU_SLTU)
  - forward-select codes (FWD_RF, FWD_EXMEM, FWD_WB)
  - FSM state enum (ST_IDLE, ST_BUSY, ST_DONE)
- One sub-module: ex_serial_mul. It contains the operand/accumulator registers, the 5-bit count and the done flag, and is started by a start pulse.

## Test plan
- ADD, R1=0x7FFFFFFF, R2=1, forward 0 -> next edge AluResult_out=0x80000000, Effective_out=1.
- SUB with R1_forward_in=1, EXMEM_fwd=10, R2=3 -> AluResult_out=7.
- Beq, A=B=5, PC=0x100, Imm=0xFFFFFFFE -> Redirect=1, Redirect_PC=0xFC in the same cycle. Bne with the same operands -> Redirect=0.
- JAL, PC=0x00400010, J_Addr=0x0100004 -> Redirect_PC=0x00400010, AluResult_out=0x00400014, Rd_no_out=31.
- MUL, A=0xFFFFFFFF, B=3 (EX_MULT_EN on) -> Stall=1 for 33 cycles with bubbles out, then AluResult_out=0xFFFFFFFD. With the macro off -> same result next edge, Stall=0.
- rst asserted in BUSY cycle 10 -> all outputs 0 next edge, Stall=0; a following ADD 2+2 gives 4.
